// File: rtl/seg7_scan_disp.sv
// Multi-digit 7-segment controller: latches a binary value, converts it to BCD (double dabble)
// or hex nibbles, commits the digits atomically, and time-multiplexes them onto one segment bus.
module seg7_scan_disp #(
    parameter int BIN_VAL_WIDTH = 14,
    parameter int DEC_DIGITS    = 4,
    parameter int REFRESH_DIV   = 1024,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BIN_VAL_WIDTH-1:0] bin_val_i,
    input  logic                     req_i,
    input  logic                     hex_mode_i,
    input  logic                     blank_lz_i,
    output logic                     busy_o,
    output logic                     overflow_o,
    output logic [7:0]               segm_o,
    output logic [DEC_DIGITS-1:0]    digit_select_o
);
    localparam int DW   = 4 * DEC_DIGITS;
    localparam int PADW = (BIN_VAL_WIDTH > DW) ? BIN_VAL_WIDTH : DW;
    localparam int CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW   = $clog2(DEC_DIGITS);
    localparam int BW   = $clog2(BIN_VAL_WIDTH + 1);

    localparam logic [7:0]            SEG_OFF  = ACTIVE_LOW ? 8'hff : 8'h00;
    localparam logic [DEC_DIGITS-1:0] SEL_NONE = ACTIVE_LOW ? '1 : '0;
    localparam logic [7:0]            GL_DASH  = 8'hbf;
    localparam logic [7:0]            GL_BLANK = 8'hff;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

    state_t                   state_q;
    logic                     busy_q, ovf_q, work_ovf_q, hex_q, blank_q, disp_blank_q;
    logic [BIN_VAL_WIDTH-1:0] bin_q;
    logic [BW-1:0]            bits_q;
    logic [DW-1:0]            work_q, buf_q;
    logic [CW-1:0]            cnt_q;
    logic [IW-1:0]            idx_q;
    logic [7:0]               segm_q;
    logic [DEC_DIGITS-1:0]    sel_q;

    // Active-low glyphs; polarity is applied separately.
    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 8'hc0;  4'h1: glyph = 8'hf9;  4'h2: glyph = 8'ha4;  4'h3: glyph = 8'hb0;
            4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hf8;
            4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'ha: glyph = 8'h88;  4'hb: glyph = 8'h83;
            4'hc: glyph = 8'hc6;  4'hd: glyph = 8'ha1;  4'he: glyph = 8'h86;  default: glyph = 8'h8e;
        endcase
    endfunction

    function automatic logic [7:0] polar(input logic [7:0] c);
        polar = ACTIVE_LOW ? c : ~c;
    endfunction

    logic [DW-1:0]   dabble_adj, dec_work_d, hex_work_d;
    logic [PADW-1:0] pad;
    logic            hex_ovf_d;

    always_comb begin
        dabble_adj = work_q;
        for (int i = 0; i < DEC_DIGITS; i++) begin
            if (work_q[4*i +: 4] > 4'd4) dabble_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        end
        dec_work_d = {dabble_adj[DW-2:0], bin_q[BIN_VAL_WIDTH-1]};
        pad        = PADW'(bin_q);
        hex_work_d = pad[DW-1:0];
        hex_ovf_d  = 1'b0;
        for (int b = DW; b < BIN_VAL_WIDTH; b++) hex_ovf_d = hex_ovf_d | bin_q[b];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            work_ovf_q   <= 1'b0;
            hex_q        <= 1'b0;
            blank_q      <= 1'b0;
            disp_blank_q <= 1'b0;
            bin_q        <= '0;
            bits_q       <= '0;
            work_q       <= '0;
            buf_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        bin_q      <= bin_val_i;
                        hex_q      <= hex_mode_i;
                        blank_q    <= blank_lz_i;
                        work_q     <= '0;
                        work_ovf_q <= 1'b0;
                        bits_q     <= BW'(BIN_VAL_WIDTH);
                        busy_q     <= 1'b1;
                        state_q    <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (hex_q) begin
                        work_q     <= hex_work_d;
                        work_ovf_q <= hex_ovf_d;
                        state_q    <= S_COMMIT;
                    end else begin
                        // A set bit leaving the top digit means the value needs one more digit.
                        work_q     <= dec_work_d;
                        work_ovf_q <= work_ovf_q | dabble_adj[DW-1];
                        bin_q      <= bin_q << 1;
                        bits_q     <= bits_q - BW'(1);
                        if (bits_q == BW'(1)) state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    buf_q        <= work_q;
                    ovf_q        <= work_ovf_q;
                    disp_blank_q <= blank_q;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [7:0]            segm_d;
    logic [DEC_DIGITS-1:0] sel_d, onehot;
    logic                  lz_blank;

    always_comb begin
        // A digit is a leading zero when it and every digit above it are zero.
        lz_blank = disp_blank_q && (idx_q != '0) && ((buf_q >> (4 * idx_q)) == '0);
        if (ovf_q)         segm_d = polar(GL_DASH);
        else if (lz_blank) segm_d = polar(GL_BLANK);
        else               segm_d = polar(glyph(buf_q[4*idx_q +: 4]));
        onehot = {{(DEC_DIGITS-1){1'b0}}, 1'b1} << idx_q;
        sel_d  = ACTIVE_LOW ? ~onehot : onehot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            segm_q <= SEG_OFF;
            sel_q  <= SEL_NONE;
        end else begin
            if (cnt_q == CW'(REFRESH_DIV - 1)) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IW'(DEC_DIGITS - 1)) ? '0 : idx_q + IW'(1);
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            segm_q <= segm_d;
            sel_q  <= sel_d;
        end
    end

    assign busy_o         = busy_q;
    assign overflow_o     = ovf_q;
    assign segm_o         = segm_q;
    assign digit_select_o = sel_q;
endmodule

// File: tb/tb_seg7_scan_disp.sv
// Bench for seg7_scan_disp: arithmetic reference model checked every cycle plus directed literal checks.
module tb_seg7_scan_disp;
    localparam int BW = 14, DD = 4, RD = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [BW-1:0] bin_val_i = '0;
    logic          req_i = 1'b0, hex_mode_i = 1'b0, blank_lz_i = 1'b0;
    logic          busy_o, overflow_o;
    logic [7:0]    segm_o;
    logic [DD-1:0] digit_select_o;

    int vectors = 0, errors = 0;

    seg7_scan_disp #(.BIN_VAL_WIDTH(BW), .DEC_DIGITS(DD), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bin_val_i(bin_val_i), .req_i(req_i),
        .hex_mode_i(hex_mode_i), .blank_lz_i(blank_lz_i), .busy_o(busy_o),
        .overflow_o(overflow_o), .segm_o(segm_o), .digit_select_o(digit_select_o)
    );

    always #5 clk = ~clk;

    logic [7:0] TBL [16] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};

    // Reference model state: what is committed, what is pending, and the scan position.
    int         m_val = 0, p_val = 0, left = 0, n = 0;
    bit         m_hex = 0, m_blank = 0, m_ovf = 0, m_busy = 0, p_hex = 0, p_blank = 0, p_ovf = 0;
    logic [7:0] e_seg = 8'hff;
    logic [3:0] e_sel = 4'hf;

    function automatic logic [7:0] disp_code(input int idx, input int v, input bit hx,
                                             input bit bl, input bit ov);
        int base, upper, d;
        if (ov) return 8'hbf;
        base  = hx ? 16 : 10;
        upper = v;
        for (int k = 0; k < idx; k++) upper = upper / base;
        d = upper % base;
        if (bl && idx > 0 && upper == 0) return 8'hff;
        return TBL[d];
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_val = 0; m_hex = 0; m_blank = 0; m_ovf = 0; m_busy = 0; left = 0; n = 0;
                e_seg = 8'hff; e_sel = 4'hf;
            end else begin
                e_seg = disp_code((n / RD) % DD, m_val, m_hex, m_blank, m_ovf);
                e_sel = ~(4'b0001 << ((n / RD) % DD));
                n++;
                if (m_busy) begin
                    left--;
                    if (left == 0) begin
                        m_val = p_val; m_hex = p_hex; m_blank = p_blank; m_ovf = p_ovf; m_busy = 0;
                    end
                end else if (req_i) begin
                    p_val   = int'(bin_val_i);
                    p_hex   = hex_mode_i;
                    p_blank = blank_lz_i;
                    p_ovf   = hex_mode_i ? (p_val >= 65536) : (p_val > 9999);
                    left    = hex_mode_i ? 2 : BW + 1;
                    m_busy  = 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("model_segm", int'(segm_o), int'(e_seg));
            chk("model_sel", int'(digit_select_o), int'(e_sel));
            chk("model_busy", int'(busy_o), int'(m_busy));
            chk("model_ovf", int'(overflow_o), int'(m_ovf));
        end
    end

    task automatic do_req(input int v, input bit hx, input bit bl, output int cyc);
        @(negedge clk);
        bin_val_i = BW'(v); hex_mode_i = hx; blank_lz_i = bl; req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        cyc = 0;
        while (busy_o && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic check_scan(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] seen [4];
        for (int k = 0; k < 4; k++) seen[k] = 8'h00;
        for (int c = 0; c < DD * RD; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                if (digit_select_o == ~(4'b0001 << k)) seen[k] = segm_o;
        end
        chk({nm, "_d0"}, int'(seen[0]), int'(e0));
        chk({nm, "_d1"}, int'(seen[1]), int'(e1));
        chk({nm, "_d2"}, int'(seen[2]), int'(e2));
        chk({nm, "_d3"}, int'(seen[3]), int'(e3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        repeat (2) @(negedge clk);
        chk("rst_segm", int'(segm_o), 8'hff);
        chk("rst_sel", int'(digit_select_o), 4'hf);
        chk("rst_busy", int'(busy_o), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_sel", int'(digit_select_o), 4'he);
        chk("first_segm", int'(segm_o), 8'hc0);

        do_req(1234, 0, 0, cyc);
        chk("dec_busy_len", cyc, 15);
        check_scan("dec1234", 8'h99, 8'hb0, 8'ha4, 8'hf9);
        chk("dec1234_ovf", int'(overflow_o), 0);

        do_req(7, 0, 1, cyc);
        check_scan("dec7_blank", 8'hf8, 8'hff, 8'hff, 8'hff);
        do_req(0, 0, 1, cyc);
        check_scan("dec0_blank", 8'hc0, 8'hff, 8'hff, 8'hff);

        do_req(12000, 0, 0, cyc);
        chk("ovf_set", int'(overflow_o), 1);
        check_scan("dec12000", 8'hbf, 8'hbf, 8'hbf, 8'hbf);
        do_req(9999, 0, 0, cyc);
        chk("ovf_clr", int'(overflow_o), 0);
        check_scan("dec9999", 8'h90, 8'h90, 8'h90, 8'h90);

        do_req(16'h1A5F, 1, 0, cyc);
        chk("hex_busy_len", cyc, 2);
        check_scan("hex1A5F", 8'h8e, 8'h92, 8'h88, 8'hf9);
        do_req(16'h000B, 1, 1, cyc);
        check_scan("hexB_blank", 8'h83, 8'hff, 8'hff, 8'hff);

        // Second request while busy must be dropped, not queued.
        @(negedge clk);
        bin_val_i = BW'(1234); hex_mode_i = 1'b0; blank_lz_i = 1'b0; req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        @(negedge clk);
        bin_val_i = BW'(4321); req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        cyc = 0;
        while (busy_o && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("ignore_idle", int'(busy_o), 0);
        check_scan("ignored", 8'h99, 8'hb0, 8'ha4, 8'hf9);
        do_req(4321, 0, 0, cyc);
        check_scan("dec4321", 8'hf9, 8'ha4, 8'hb0, 8'h99);

        // Reset in the middle of a conversion discards it.
        @(negedge clk);
        bin_val_i = BW'(5678); req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_segm", int'(segm_o), 8'hff);
        chk("midrst_sel", int'(digit_select_o), 4'hf);
        chk("midrst_busy", int'(busy_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_sel", int'(digit_select_o), 4'he);
        chk("rel_segm", int'(segm_o), 8'hc0);
        check_scan("after_rst", 8'hc0, 8'hc0, 8'hc0, 8'hc0);
        chk("after_rst_busy", int'(busy_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
